biu_mem_arbiter: RTL

- Two-port arbiter that shares one memory bus between the instruction-fetch port and the data-memory port of the RV12 core.
- Sits between the core's if/dmem request interfaces and the single external BIU.
- Data accesses win by default. A starvation counter guarantees fetch progress.
- A lock input keeps the bus on the data port for atomic sequences.

---
 rtl/biu_pkg.sv | 10 +
 rtl/biu_mem_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/biu_pkg.sv
// rtl/biu_pkg.sv - bus transfer size type shared by the core memory interfaces
package biu_pkg;
  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HWORD = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011,
    QWORD = 3'b100
  } biu_size_t;
endpackage

// File: rtl/biu_mem_arbiter.sv
// rtl/biu_mem_arbiter.sv - fetch/data arbiter onto one BIU with data priority and fetch anti-starvation
// Optional bus watchdog enabled by defining BIU_ARB_TIMEOUT_EN.
module biu_mem_arbiter
  import biu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int MAX_DBURST     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            imem_req,
  input  logic [XLEN-1:0] imem_adr,
  output logic [XLEN-1:0] imem_q,
  output logic            imem_ack,
  output logic            imem_err,
  input  logic            dmem_req,
  input  logic            dmem_lock,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic [XLEN-1:0] dmem_d,
  input  logic            dmem_we,
  input  biu_size_t       dmem_size,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_ack,
  output logic            dmem_err,
  output logic            bus_req,
  output logic [XLEN-1:0] bus_adr,
  output logic [XLEN-1:0] bus_d,
  output logic            bus_we,
  output biu_size_t       bus_size,
  input  logic [XLEN-1:0] bus_q,
  input  logic            bus_ack,
  input  logic            bus_err,
  output logic            grant_d
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, LOCK_D} state_t;

  localparam logic [3:0] MAX_D = 4'(MAX_DBURST);

  state_t     state;
  logic [3:0] dburst_cnt;
  logic       busy_i, busy_d, tout, fail, done, d_release;

  assign busy_i = (state == BUSY_I);
  assign busy_d = (state == BUSY_D);

`ifdef BIU_ARB_TIMEOUT_EN
  localparam logic [7:0] TOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wdog;

  // Held at zero outside BUSY so every new grant starts a fresh count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 wdog <= '0;
    else if (busy_i || busy_d) wdog <= wdog + 8'd1;
    else                       wdog <= '0;
  end

  assign tout = (busy_i || busy_d) && (wdog == TOUT_LIMIT);
`else
  assign tout = 1'b0;
`endif

  assign fail = bus_err | tout;
  assign done = bus_ack | fail;
  // A timed-out data access never parks the bus in LOCK_D.
  assign d_release = !dmem_lock || tout;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      dburst_cnt <= '0;
      grant_d    <= 1'b0;
      bus_req    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dmem_req && !(imem_req && dburst_cnt == MAX_D)) begin
            state   <= BUSY_D;
            bus_req <= 1'b1;
            grant_d <= 1'b1;
          end else if (imem_req) begin
            state   <= BUSY_I;
            bus_req <= 1'b1;
            grant_d <= 1'b0;
          end
        end
        BUSY_I: begin
          if (done) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            dburst_cnt <= '0;
          end
        end
        BUSY_D: begin
          if (done) begin
            bus_req <= 1'b0;
            if (d_release) begin
              state   <= IDLE;
              grant_d <= 1'b0;
              if (imem_req && dburst_cnt != MAX_D) dburst_cnt <= dburst_cnt + 4'd1;
            end else begin
              state <= LOCK_D;
            end
          end
        end
        LOCK_D: begin
          if (dmem_req) begin
            state   <= BUSY_D;
            bus_req <= 1'b1;
          end else if (!dmem_lock) begin
            state   <= IDLE;
            grant_d <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
          grant_d <= 1'b0;
        end
      endcase
    end
  end

  assign bus_adr  = grant_d ? dmem_adr  : imem_adr;
  assign bus_d    = grant_d ? dmem_d    : '0;
  assign bus_we   = grant_d & dmem_we;
  assign bus_size = grant_d ? dmem_size : WORD;

  assign imem_q = bus_q;
  assign dmem_q = bus_q;

  // Error wins over ack so a requester never sees both in one cycle.
  assign imem_ack = busy_i & bus_ack & ~fail;
  assign imem_err = busy_i & fail;
  assign dmem_ack = busy_d & bus_ack & ~fail;
  assign dmem_err = busy_d & fail;

endmodule
